// File: rtl/fifo_pkg.sv
// Shared sizing for the 8x8 FIFO sequencing controller.
// The thresholds set the default almost_full and almost_empty levels.
package fifo_pkg;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned AF_LVL_DEF = 6;
  localparam int unsigned AE_LVL_DEF = 2;

  // Pointers carry one extra wrap bit above the RAM address.
  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer/RAM-facing bundle of the FIFO controller.
// The master modport is the parent that owns the RAM.
interface fifo_if;
  import fifo_pkg::*;

  logic  push;
  logic  pop;
  logic  err_clr;
  logic  mem_we;
  logic  mem_re;
  addr_t mem_waddr;
  addr_t mem_raddr;
  logic  rd_valid;
  logic  full;
  logic  empty;
  logic  almost_full;
  logic  almost_empty;
  ptr_t  count;
  logic  overflow;
  logic  underflow;

  modport master (
    output push, pop, err_clr,
    input  mem_we, mem_re, mem_waddr, mem_raddr, rd_valid, full, empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, err_clr,
    output mem_we, mem_re, mem_waddr, mem_raddr, rd_valid, full, empty,
    output almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with an extra MSB wrap bit.
// The pointer has a synchronous reset and increments when enabled.
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  output ptr_t o_ptr
);

  ptr_t r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + ptr_t'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the 8x8 two-port FIFO RAM.
// It tracks the pointers, decodes the flags and latches sticky request errors.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AF_LVL = AF_LVL_DEF,
  parameter int unsigned AE_LVL = AE_LVL_DEF
) (
  input logic    i_clk,
  input logic    i_rst,
  fifo_if.slave  bus
);

  localparam ptr_t AF_CNT = ptr_t'(AF_LVL);
  localparam ptr_t AE_CNT = ptr_t'(AE_LVL);

  ptr_t w_wr_ptr;
  ptr_t w_rd_ptr;
  ptr_t w_count;
  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;
  logic r_rd_valid;
  logic r_overflow;
  logic r_underflow;

  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]) &&
                   (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]);
  assign w_count = w_wr_ptr - w_rd_ptr;

  // A push at full is accepted only when a pop frees the slot in the same cycle.
  assign w_pop_ok  = bus.pop & ~w_empty & ~i_rst;
  assign w_push_ok = bus.push & (~w_full | w_pop_ok) & ~i_rst;

  fifo_ptr u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_push_ok),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_pop_ok),
    .o_ptr (w_rd_ptr)
  );

  // Setting an error flag takes priority over err_clr in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid  <= w_pop_ok;
      r_overflow  <= (bus.push & ~w_push_ok) | (r_overflow & ~bus.err_clr);
      r_underflow <= (bus.pop & ~w_pop_ok) | (r_underflow & ~bus.err_clr);
    end
  end

  assign bus.mem_we       = w_push_ok;
  assign bus.mem_re       = w_pop_ok;
  assign bus.mem_waddr    = w_wr_ptr[ADDR_W-1:0];
  assign bus.mem_raddr    = w_rd_ptr[ADDR_W-1:0];
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (w_count >= AF_CNT);
  assign bus.almost_empty = (w_count <= AE_CNT);
  assign bus.count        = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl driving a behavioural 8x8 two-port RAM.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] ram [DEPTH];
  int         total;
  int         bad;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  fifo_if u_if ();

  fifo_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  // Read-before-write RAM: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (u_if.mem_we) ram[u_if.mem_waddr] <= wdata;
    if (u_if.mem_re) rdata <= ram[u_if.mem_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic c, input logic [7:0] d);
    u_if.push    = p;
    u_if.pop     = q;
    u_if.err_clr = c;
    wdata        = d;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    chk("rst_we", 32'(u_if.mem_we), 32'd0);
    chk("rst_re", 32'(u_if.mem_re), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_empty", 32'(u_if.empty), 32'd1);
    chk("rst_full", 32'(u_if.full), 32'd0);
    chk("rst_ae", 32'(u_if.almost_empty), 32'd1);
    chk("rst_af", 32'(u_if.almost_full), 32'd0);
    chk("rst_count", 32'(u_if.count), 32'd0);
    chk("rst_rdv", 32'(u_if.rd_valid), 32'd0);
    chk("rst_ovf", 32'(u_if.overflow), 32'd0);
    chk("rst_unf", 32'(u_if.underflow), 32'd0);
    chk("rst_waddr", 32'(u_if.mem_waddr), 32'd0);
    chk("rst_raddr", 32'(u_if.mem_raddr), 32'd0);

    // 1: fill then drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      chk("fill_we", 32'(u_if.mem_we), 32'd1);
      chk("fill_waddr", 32'(u_if.mem_waddr), 32'(i));
      tick();
      chk("fill_count", 32'(u_if.count), 32'(i + 1));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("fill_full", 32'(u_if.full), 32'd1);
    chk("fill_af", 32'(u_if.almost_full), 32'd1);
    chk("fill_cnt8", 32'(u_if.count), 32'(DEPTH));
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_re", 32'(u_if.mem_re), 32'd1);
      chk("drain_raddr", 32'(u_if.mem_raddr), 32'(i));
      tick();
      chk("drain_rdv", 32'(u_if.rd_valid), 32'd1);
      chk("drain_data", 32'(rdata), 32'(8'h10 + i));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain_empty", 32'(u_if.empty), 32'd1);
    chk("drain_ovf", 32'(u_if.overflow), 32'd0);
    chk("drain_unf", 32'(u_if.underflow), 32'd0);
    tick();
    chk("idle_rdv", 32'(u_if.rd_valid), 32'd0);

    // 2: overflow at full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 8'h99);
    chk("ovf_we", 32'(u_if.mem_we), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_count", 32'(u_if.count), 32'd8);
    chk("ovf_flag", 32'(u_if.overflow), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 8'h99);
    tick();
    chk("ovf_set_wins", 32'(u_if.overflow), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    chk("ovf_clr", 32'(u_if.overflow), 32'd0);

    // 4: simultaneous push+pop at full
    drive(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("sim_we", 32'(u_if.mem_we), 32'd1);
    chk("sim_re", 32'(u_if.mem_re), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("sim_count", 32'(u_if.count), 32'd8);
    chk("sim_data", 32'(rdata), 32'h20);
    chk("sim_waddr", 32'(u_if.mem_waddr), 32'd1);
    chk("sim_raddr", 32'(u_if.mem_raddr), 32'd1);
    for (int i = 1; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      chk("sim_drain", 32'(rdata), (i == 8) ? 32'hAA : 32'(8'h20 + i));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("sim_empty", 32'(u_if.empty), 32'd1);

    // 3: underflow, alone and with push
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_re", 32'(u_if.mem_re), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("unf_rdv", 32'(u_if.rd_valid), 32'd0);
    chk("unf_flag", 32'(u_if.underflow), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    chk("unf_clr", 32'(u_if.underflow), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h30);
    chk("unfp_we", 32'(u_if.mem_we), 32'd1);
    chk("unfp_re", 32'(u_if.mem_re), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unfp_count", 32'(u_if.count), 32'd1);
    chk("unfp_flag", 32'(u_if.underflow), 32'd1);
    chk("unfp_rdv", 32'(u_if.rd_valid), 32'd0);
    tick();

    // 5: steady-state wrap at count = 3
    exp_q = '{8'h30, 8'h31, 8'h32};
    for (int i = 1; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
      tick();
      exp_v = exp_q.pop_front();
      chk("wrap_data", 32'(rdata), 32'(exp_v));
      chk("wrap_count", 32'(u_if.count), 32'd3);
      chk("wrap_ae", 32'(u_if.almost_empty), 32'd0);
      chk("wrap_af", 32'(u_if.almost_full), 32'd0);
    end

    // 6: reset right after an accepted pop at count = 5
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("pre_rst_count", 32'(u_if.count), 32'd5);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("mid_rst_rdv", 32'(u_if.rd_valid), 32'd0);
    chk("mid_rst_count", 32'(u_if.count), 32'd0);
    chk("mid_rst_empty", 32'(u_if.empty), 32'd1);
    chk("mid_rst_waddr", 32'(u_if.mem_waddr), 32'd0);
    chk("mid_rst_raddr", 32'(u_if.mem_raddr), 32'd0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
